// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared widths, the write-back entry record and the
//                source-select encoding for the register-file write arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    // One pending register-file write. The destination field is named rd
    // because "reg" is a reserved word.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Which producer owns the write port in a given cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_BUF  = 2'd2
    } sel_e;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Small FIFO of write-back entries for the long-latency path.
//                Registered head, no bypass: a pushed entry becomes visible
//                at the head only after the push edge.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  wb_entry_t        i_push_entry,
    input  logic             i_pop,
    output wb_entry_t        o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(BUF_DEPTH - 1);

    wb_entry_t          r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    assign o_full  = (r_count == CNT_W'(BUF_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Entry storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointer and occupancy tracking; pointers wrap for any depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Arbitrates the single register-file write port between the
//                single-cycle ALU writeback and a buffered long-latency
//                (load / long-op) path, with starvation protection for the
//                buffer and a busy scoreboard of pending long-op destinations.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int NREG         = 32,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_reg,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic [NREG-1:0]   busy,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data
);

    import wb_pkg::*;

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] c_starve_limit = STV_W'(STARVE_LIMIT);
    // Register 0 is hard-wired, so its busy bit can never be set.
    localparam logic [NREG-1:0]  c_busy_mask    = {{(NREG-1){1'b1}}, 1'b0};

    wb_entry_t          w_push_entry;
    wb_entry_t          w_head;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic               w_push;
    logic               w_pop;
    logic               w_starved;
    sel_e               w_sel;
    logic [NREG-1:0]    w_busy_set;
    logic [NREG-1:0]    w_busy_clr;

    logic [STV_W-1:0]   r_starve;
    logic [NREG-1:0]    r_busy;
    logic               r_regwrite;
    logic [ADDR_W-1:0]  r_write_reg;
    logic [DATA_W-1:0]  r_write_data;

    assign w_push_entry = '{rd: lsu_reg, data: lsu_data};

    // A buffered entry that has waited long enough takes the port; the ALU
    // is held off for exactly that cycle.
    assign w_starved  = (w_count != '0) && (r_starve == c_starve_limit);
    assign alu_ready  = !w_starved;
    assign lsu_ready  = !w_full;
    assign w_push     = lsu_valid && lsu_ready;
    assign w_pop      = (w_sel == SEL_BUF);

    assign busy       = r_busy;
    assign RegWrite   = r_regwrite;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;

    wb_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count)
    );

    // Port owner this cycle: accepted ALU first, otherwise the buffer head.
    always_comb begin
        w_sel = SEL_NONE;
        if (alu_valid && alu_ready) begin
            w_sel = SEL_ALU;
        end else if (!w_empty) begin
            w_sel = SEL_BUF;
        end
    end

    // Count cycles the buffer head is kept waiting behind the ALU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_pop || w_empty) begin
            r_starve <= '0;
        end else begin
            r_starve <= r_starve + STV_W'(1);
        end
    end

    // Register the chosen entry onto the write port; writes to register 0
    // are consumed but suppressed, and idle cycles hold address and data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite   <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            unique case (w_sel)
                SEL_ALU: begin
                    r_regwrite <= (alu_reg != '0);
                    if (alu_reg != '0) begin
                        r_write_reg  <= alu_reg;
                        r_write_data <= alu_data;
                    end
                end
                SEL_BUF: begin
                    r_regwrite <= (w_head.rd != '0);
                    if (w_head.rd != '0) begin
                        r_write_reg  <= w_head.rd;
                        r_write_data <= w_head.data;
                    end
                end
                default: r_regwrite <= 1'b0;
            endcase
        end
    end

    // Scoreboard set/clear requests for this edge.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (issue_valid && (issue_reg != '0)) begin
            w_busy_set[issue_reg] = 1'b1;
        end
        if (w_pop && (w_head.rd != '0)) begin
            w_busy_clr[w_head.rd] = 1'b1;
        end
    end

    // Busy scoreboard: a new issue wins over a retiring entry to the same reg.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & c_busy_mask;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Directed self-checking bench for regfile_write_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_reg;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic [31:0] busy;
    logic        RegWrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    int n_vec;
    int n_err;

    regfile_write_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .NREG         (32),
        .BUF_DEPTH    (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_reg     (lsu_reg),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .busy        (busy),
        .RegWrite    (RegWrite),
        .write_reg   (write_reg),
        .write_data  (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_reg = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_reg = '0;
        #2;
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
        n_vec++; if (write_reg !== 5'd0) begin n_err++; $display("FAIL reset_write_reg: got %0d expected 0", write_reg); end
        n_vec++; if (write_data !== 32'd0) begin n_err++; $display("FAIL reset_write_data: got %h expected 0", write_data); end
        n_vec++; if (busy !== 32'd0) begin n_err++; $display("FAIL reset_busy: got %h expected 0", busy); end
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_alu_ready: got %b expected 1", alu_ready); end
        n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL reset_lsu_ready: got %b expected 1", lsu_ready); end
        #1;
        rst = 1'b1;
        step();
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready: got %b expected 1", alu_ready); end
        step();
        alu_valid = 1'b0;
        n_vec++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL alu_regwrite: got %b expected 1", RegWrite); end
        n_vec++; if (write_reg !== 5'd5) begin n_err++; $display("FAIL alu_write_reg: got %0d expected 5", write_reg); end
        n_vec++; if (write_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_write_data: got %h expected deadbeef", write_data); end
        step();
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL alu_idle_regwrite: got %b expected 0", RegWrite); end
    endtask

    task automatic test_reg_zero();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h11111111;
        issue_valid = 1'b1; issue_reg = 5'd0;
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL r0_alu_ready: got %b expected 1", alu_ready); end
        step();
        alu_valid = 1'b0; issue_valid = 1'b0;
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL r0_alu_regwrite: got %b expected 0", RegWrite); end
        n_vec++; if (busy !== 32'd0) begin n_err++; $display("FAIL r0_busy: got %h expected 0", busy); end
    endtask

    task automatic test_long_op();
        issue_valid = 1'b1; issue_reg = 5'd9;
        step();
        issue_valid = 1'b0;
        n_vec++; if (busy !== 32'h00000200) begin n_err++; $display("FAIL lop_busy_set: got %h expected 00000200", busy); end
        lsu_valid = 1'b1; lsu_reg = 5'd9; lsu_data = 32'h1234;
        n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL lop_lsu_ready: got %b expected 1", lsu_ready); end
        step();
        lsu_valid = 1'b0;
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL lop_no_bypass: got %b expected 0", RegWrite); end
        n_vec++; if (busy !== 32'h00000200) begin n_err++; $display("FAIL lop_busy_hold: got %h expected 00000200", busy); end
        step();
        n_vec++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL lop_regwrite: got %b expected 1", RegWrite); end
        n_vec++; if (write_reg !== 5'd9) begin n_err++; $display("FAIL lop_write_reg: got %0d expected 9", write_reg); end
        n_vec++; if (write_data !== 32'h1234) begin n_err++; $display("FAIL lop_write_data: got %h expected 00001234", write_data); end
        n_vec++; if (busy !== 32'd0) begin n_err++; $display("FAIL lop_busy_clear: got %h expected 0", busy); end
        // Long-op to register 0 is consumed without a write.
        lsu_valid = 1'b1; lsu_reg = 5'd0; lsu_data = 32'h55;
        step();
        lsu_valid = 1'b0;
        step();
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL lop_r0_regwrite: got %b expected 0", RegWrite); end
        step();
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL lop_r0_drained: got %b expected 0", RegWrite); end
    endtask

    task automatic test_fill_starve();
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hA;
        lsu_valid = 1'b1; lsu_reg = 5'd10; lsu_data = 32'h100;
        step();
        lsu_reg = 5'd11; lsu_data = 32'h200;
        n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_one: got %b expected 1", lsu_ready); end
        step();
        lsu_valid = 1'b0;
        n_vec++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL fill_full: got %b expected 0", lsu_ready); end
        n_vec++; if (RegWrite !== 1'b1 || write_reg !== 5'd3) begin n_err++; $display("FAIL fill_alu_wins: got we=%b reg=%0d expected we=1 reg=3", RegWrite, write_reg); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_wait%0d: got %b expected 1", i, alu_ready); end
            step();
        end
        n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL starve_hold: got %b expected 0", alu_ready); end
        n_vec++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL starve_still_full: got %b expected 0", lsu_ready); end
        step();
        n_vec++; if (RegWrite !== 1'b1 || write_reg !== 5'd10 || write_data !== 32'h100) begin n_err++; $display("FAIL starve_pop: got we=%b reg=%0d data=%h expected we=1 reg=10 data=00000100", RegWrite, write_reg, write_data); end
        n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL starve_ready_back: got %b expected 1", lsu_ready); end
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_alu_back: got %b expected 1", alu_ready); end
        alu_valid = 1'b0;
        step();
        n_vec++; if (RegWrite !== 1'b1 || write_reg !== 5'd11 || write_data !== 32'h200) begin n_err++; $display("FAIL drain_second: got we=%b reg=%0d data=%h expected we=1 reg=11 data=00000200", RegWrite, write_reg, write_data); end
        step();
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b expected 0", RegWrite); end
    endtask

    task automatic test_simultaneous();
        issue_valid = 1'b1; issue_reg = 5'd7;
        step();
        issue_valid = 1'b0;
        lsu_valid = 1'b1; lsu_reg = 5'd7; lsu_data = 32'h77;
        step();
        // Head (reg 7) pops this cycle while reg 7 is re-issued and reg 8 pushed.
        issue_valid = 1'b1; issue_reg = 5'd7;
        lsu_reg = 5'd8; lsu_data = 32'h88;
        step();
        issue_valid = 1'b0; lsu_valid = 1'b0;
        n_vec++; if (RegWrite !== 1'b1 || write_reg !== 5'd7) begin n_err++; $display("FAIL sim_pop7: got we=%b reg=%0d expected we=1 reg=7", RegWrite, write_reg); end
        n_vec++; if (busy !== 32'h00000080) begin n_err++; $display("FAIL sim_set_wins: got %h expected 00000080", busy); end
        n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL sim_count_one: got %b expected 1", lsu_ready); end
        step();
        n_vec++; if (RegWrite !== 1'b1 || write_reg !== 5'd8 || write_data !== 32'h88) begin n_err++; $display("FAIL sim_pop8: got we=%b reg=%0d data=%h expected we=1 reg=8 data=00000088", RegWrite, write_reg, write_data); end
        step();
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL sim_empty: got %b expected 0", RegWrite); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        step();
        issue_valid = 1'b1; issue_reg = 5'd8;
        step();
        issue_reg = 5'd9;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h44;
        lsu_valid = 1'b1; lsu_reg = 5'd8; lsu_data = 32'h808;
        step();
        lsu_reg = 5'd9; lsu_data = 32'h909;
        step();
        lsu_valid = 1'b0;
        n_vec++; if (busy !== 32'h00000300) begin n_err++; $display("FAIL mid_busy_pre: got %h expected 00000300", busy); end
        n_vec++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL mid_full_pre: got %b expected 0", lsu_ready); end
        n_vec++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL mid_we_pre: got %b expected 1", RegWrite); end
        rst = 1'b0;
        #2;
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL mid_async_we: got %b expected 0", RegWrite); end
        n_vec++; if (busy !== 32'd0) begin n_err++; $display("FAIL mid_async_busy: got %h expected 0", busy); end
        n_vec++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL mid_async_ready: got %b expected 1", lsu_ready); end
        alu_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL mid_no_stale%0d: got %b expected 0", i, RegWrite); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_alu_only();
        test_reg_zero();
        test_long_op();
        test_fill_starve();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
